snn_axi_lite_responder: RTL and testbench
=========================================

// Module: snn_axi_lite_responder
// PURPOSE
// - AXI4-Lite slave (responder) in snn_core_top; terminates host register/memory traffic.
// - Holds CTRL/SIM_TIME/MEM_CFG, returns read-only DEBUG status.
// - Forwards the 0x0100-0x01FF window to the memory selected by MEM_CFG (spike-gen, synapse, spike-pattern).
// - Independent write and read FSMs; one outstanding transaction per channel.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  data width; only 32 supported
// C_S_AXI_ADDR_WIDTH  16  byte address width
// MEM_RD_LATENCY      1   cycles from mem_rd_en to valid mem_rd_data (1..7)
// USE_WSTRB           0   0: ignore WSTRB, full-word writes; 1: per-byte enables on regs
// PORTS
// S_AXI_ACLK     in  1   clock
// S_AXI_ARESETN  in  1   async active-low reset
// S_AXI_AWADDR/AWVALID in 16/1; S_AXI_AWREADY out 1       write address channel
// S_AXI_WDATA/WSTRB/WVALID in 32/4/1; S_AXI_WREADY out 1  write data channel
// S_AXI_BRESP/BVALID out 2/1; S_AXI_BREADY in 1           write response channel
// S_AXI_ARADDR/ARVALID in 16/1; S_AXI_ARREADY out 1       read address channel
// S_AXI_RDATA/RRESP/RVALID out 32/2/1; S_AXI_RREADY in 1  read data channel
// ctrl_reg/sim_time_reg/mem_cfg_reg  out  32 each  register contents
// ctrl_wr_pulse  out  1   one-cycle strobe on any accepted CTRL write
// debug_in       in  32  value returned for DEBUG reads
// mem_wr_en/mem_wr_addr/mem_wr_data  out  1/8/32  window write, one-cycle pulse
// mem_rd_en/mem_rd_addr  out  1/8  window read request, one-cycle pulse
// mem_rd_data    in  32  window read data, valid MEM_RD_LATENCY cycles after mem_rd_en
// BEHAVIOUR
// - Reset: READY/VALID outputs, pulses, *_reg, RDATA = 0; BRESP/RRESP = 2'b00; FSMs -> IDLE.
//   Assertion mid-transaction drops it: no B/R response, no mem pulse afterwards.
// - Decode, full-address equality: 0x0000 CTRL RW, 0x0004 SIM_TIME RW, 0x0008 MEM_CFG RW, 0x000C DEBUG RO.
//   ADDR[15:8]==8'h01 -> window, mem addr = ADDR[7:0] (byte address, no shift). Else unmapped.
// - Write FSM W_IDLE -> W_ACK -> W_RESP:
//   W_IDLE: AWVALID&&WVALID at edge N -> W_ACK. Either alone: wait, no ready asserted.
//   W_ACK: AWREADY=WREADY=1 for one cycle; at edge N+1 latch AWADDR/WDATA, perform write, BVALID=1 -> W_RESP.
//   W_RESP: hold BVALID/BRESP until BVALID&&BREADY -> W_IDLE; no new AW/W accepted meanwhile.
// - Write effect (at handshake edge):
//   CTRL/SIM_TIME/MEM_CFG update; USE_WSTRB=1 -> only lanes with WSTRB[b]=1 change.
//   CTRL write -> ctrl_wr_pulse high for the following cycle.
//   Window: mem_wr_en/addr/data valid for the following cycle, WSTRB ignored. BRESP=OKAY.
//   DEBUG or unmapped: no state change, BRESP=SLVERR (2'b10).
// - Read FSM R_IDLE -> R_ACK -> (R_MEM) -> R_DATA:
//   R_IDLE: ARVALID at edge N -> R_ACK; ARREADY=1 for one cycle, AR handshake at edge N+1.
//   Register/unmapped: RDATA captured at that edge, RVALID from N+1.
//   Window: mem_rd_en pulse in cycle N+1 -> R_MEM; capture mem_rd_data MEM_RD_LATENCY cycles later, then RVALID.
//   R_DATA: hold RVALID/RDATA/RRESP until RREADY -> R_IDLE.
//   Unmapped read: RDATA=0, RRESP=SLVERR; others OKAY.
// - Same-cycle read and write handshakes to one register: read returns pre-write value.
// - Window write and read in the same cycle: both pulses issued; ordering is the memory's concern.
// - Registers are plain storage: no self-clearing bits, readback equals last write.
// TESTING
// - Reset: all outputs 0; after release CTRL/SIM_TIME/MEM_CFG read back 0, RRESP=00.
// - Write 0xDEADBEEF to 0x0000 with WSTRB=0, USE_WSTRB=0 -> ctrl_reg=DEADBEEF, ctrl_wr_pulse one cycle, BRESP=00; read -> DEADBEEF.
// - Write 0x12345678 to 0x0103 -> mem_wr_en one cycle, mem_wr_addr=0x03, mem_wr_data=0x12345678.
// - MEM_RD_LATENCY=2, read 0x0102 with model returning 0xA5A5_0F0F -> mem_rd_addr=0x02; RVALID 2 cycles after mem_rd_en, RDATA=A5A50F0F.
// - Write 0x0040 and 0x000C -> BRESP=10, no register change; read 0x0040 -> RDATA=0, RRESP=10.
// - BREADY low 5 cycles -> BVALID held, second write not accepted until B handshake.
// - Reset asserted in R_MEM -> no RVALID.

Source files
------------

// File: rtl/snn_axi_lite_responder.sv
`default_nettype none
// ============================================================================
// Module      : snn_axi_lite_responder
// Description : AXI4-Lite responder for snn_core_top. Holds the CTRL, SIM_TIME
//               and MEM_CFG registers, returns DEBUG status and forwards the
//               0x0100-0x01FF window to the memory selected by MEM_CFG.
//               Independent write and read FSMs, one outstanding transaction
//               per channel.
// Ports       : S_AXI_*        AXI4-Lite slave interface (clock/async reset)
//               ctrl_reg, sim_time_reg, mem_cfg_reg  register contents
//               ctrl_wr_pulse  one-cycle strobe after any accepted CTRL write
//               debug_in       value returned for DEBUG reads
//               mem_wr_*       window write, one-cycle pulse
//               mem_rd_*       window read request pulse / returned data
// Revision    : 1.0 - initial release
// ============================================================================
module snn_axi_lite_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int MEM_RD_LATENCY     = 1,
  parameter int USE_WSTRB          = 0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   sim_time_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_cfg_reg,
  output logic                            ctrl_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   debug_in,
  output logic                            mem_wr_en,
  output logic [7:0]                      mem_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wr_data,
  output logic                            mem_rd_en,
  output logic [7:0]                      mem_rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int         c_NUM_LANES   = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [15:0] c_ADDR_CTRL  = 16'h0000;
  localparam logic [15:0] c_ADDR_SIM   = 16'h0004;
  localparam logic [15:0] c_ADDR_CFG   = 16'h0008;
  localparam logic [15:0] c_ADDR_DBG   = 16'h000C;
  localparam logic [7:0]  c_WIN_PAGE   = 8'h01;
  // Last value of the latency counter before mem_rd_data is sampled.
  localparam logic [2:0]  c_LAT_LAST   = 3'(MEM_RD_LATENCY - 1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_MEM = 2'd2, R_DATA = 2'd3} rd_state_t;

  wr_state_t r_wr_state;
  rd_state_t r_rd_state;

  logic                          r_awready, r_wready, r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_arready, r_rvalid;
  logic [1:0]                    r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_ctrl, r_sim, r_cfg;
  logic                          r_ctrl_wr_pulse;
  logic                          r_mem_wr_en;
  logic [7:0]                    r_mem_wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem_wr_data;
  logic                          r_mem_rd_en;
  logic [7:0]                    r_mem_rd_addr;
  logic [2:0]                    r_lat_cnt;

  // Full-address decode for both channels.
  logic w_aw_ctrl, w_aw_sim, w_aw_cfg, w_aw_win;
  logic w_ar_ctrl, w_ar_sim, w_ar_cfg, w_ar_dbg, w_ar_win;
  assign w_aw_ctrl = (S_AXI_AWADDR == c_ADDR_CTRL);
  assign w_aw_sim  = (S_AXI_AWADDR == c_ADDR_SIM);
  assign w_aw_cfg  = (S_AXI_AWADDR == c_ADDR_CFG);
  assign w_aw_win  = (S_AXI_AWADDR[15:8] == c_WIN_PAGE);
  assign w_ar_ctrl = (S_AXI_ARADDR == c_ADDR_CTRL);
  assign w_ar_sim  = (S_AXI_ARADDR == c_ADDR_SIM);
  assign w_ar_cfg  = (S_AXI_ARADDR == c_ADDR_CFG);
  assign w_ar_dbg  = (S_AXI_ARADDR == c_ADDR_DBG);
  assign w_ar_win  = (S_AXI_ARADDR[15:8] == c_WIN_PAGE);

  // Byte-lane write mask; all lanes enabled when strobes are ignored.
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wmask;
  generate
    for (genvar b = 0; b < c_NUM_LANES; b++) begin : g_lane_mask
      assign w_wmask[8*b +: 8] = (USE_WSTRB != 0) ? {8{S_AXI_WSTRB[b]}} : 8'hFF;
    end
  endgenerate

  logic [C_S_AXI_DATA_WIDTH-1:0] w_ctrl_next, w_sim_next, w_cfg_next;
  assign w_ctrl_next = (r_ctrl & ~w_wmask) | (S_AXI_WDATA & w_wmask);
  assign w_sim_next  = (r_sim  & ~w_wmask) | (S_AXI_WDATA & w_wmask);
  assign w_cfg_next  = (r_cfg  & ~w_wmask) | (S_AXI_WDATA & w_wmask);

  // Register read mux; unmapped addresses return zero with SLVERR.
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]                    w_rd_resp;
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_RESP_OKAY;
    if (w_ar_ctrl)      w_rd_data = r_ctrl;
    else if (w_ar_sim)  w_rd_data = r_sim;
    else if (w_ar_cfg)  w_rd_data = r_cfg;
    else if (w_ar_dbg)  w_rd_data = debug_in;
    else                w_rd_resp = c_RESP_SLVERR;
  end

  // Write channel: AW and W are only accepted together, one transaction at a time.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_state      <= W_IDLE;
      r_awready       <= 1'b0;
      r_wready        <= 1'b0;
      r_bvalid        <= 1'b0;
      r_bresp         <= c_RESP_OKAY;
      r_ctrl          <= '0;
      r_sim           <= '0;
      r_cfg           <= '0;
      r_ctrl_wr_pulse <= 1'b0;
      r_mem_wr_en     <= 1'b0;
      r_mem_wr_addr   <= '0;
      r_mem_wr_data   <= '0;
    end else begin
      r_ctrl_wr_pulse <= 1'b0;
      r_mem_wr_en     <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_ACK;
          end
        end
        W_ACK: begin
          // Handshake edge: apply the write and raise the response.
          r_awready  <= 1'b0;
          r_wready   <= 1'b0;
          r_bvalid   <= 1'b1;
          r_bresp    <= c_RESP_OKAY;
          r_wr_state <= W_RESP;
          if (w_aw_win) begin
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= S_AXI_AWADDR[7:0];
            r_mem_wr_data <= S_AXI_WDATA;
          end else if (w_aw_ctrl) begin
            r_ctrl          <= w_ctrl_next;
            r_ctrl_wr_pulse <= 1'b1;
          end else if (w_aw_sim) begin
            r_sim <= w_sim_next;
          end else if (w_aw_cfg) begin
            r_cfg <= w_cfg_next;
          end else begin
            r_bresp <= c_RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: registers answer immediately, the window waits out the memory latency.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rd_state    <= R_IDLE;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rresp       <= c_RESP_OKAY;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_lat_cnt     <= '0;
    end else begin
      r_mem_rd_en <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            r_arready  <= 1'b1;
            r_rd_state <= R_ACK;
          end
        end
        R_ACK: begin
          r_arready <= 1'b0;
          if (w_ar_win) begin
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= S_AXI_ARADDR[7:0];
            r_lat_cnt     <= '0;
            r_rd_state    <= R_MEM;
          end else begin
            // Registers sampled here are pre-write if a write lands on the same edge.
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_DATA;
          end
        end
        R_MEM: begin
          if (r_lat_cnt == c_LAT_LAST) begin
            r_rdata    <= mem_rd_data;
            r_rresp    <= c_RESP_OKAY;
            r_rvalid   <= 1'b1;
            r_rd_state <= R_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign ctrl_reg      = r_ctrl;
  assign sim_time_reg  = r_sim;
  assign mem_cfg_reg   = r_cfg;
  assign ctrl_wr_pulse = r_ctrl_wr_pulse;
  assign mem_wr_en     = r_mem_wr_en;
  assign mem_wr_addr   = r_mem_wr_addr;
  assign mem_wr_data   = r_mem_wr_data;
  assign mem_rd_en     = r_mem_rd_en;
  assign mem_rd_addr   = r_mem_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_snn_axi_lite_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_axi_lite_responder
// Description : Self-checking bench for snn_axi_lite_responder with a window
//               memory of read latency 2 and full-word writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_axi_lite_responder;

  localparam int LAT = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [15:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] ctrl_reg, sim_time_reg, mem_cfg_reg;
  logic        ctrl_wr_pulse;
  logic [31:0] debug_in = 32'h0BAD_F00D;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;

  snn_axi_lite_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(16),
    .MEM_RD_LATENCY    (LAT),
    .USE_WSTRB         (0)
  ) dut (
    .S_AXI_ACLK   (aclk),
    .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .ctrl_reg     (ctrl_reg),
    .sim_time_reg (sim_time_reg),
    .mem_cfg_reg  (mem_cfg_reg),
    .ctrl_wr_pulse(ctrl_wr_pulse),
    .debug_in     (debug_in),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Reference model state: register file and window memory contents.
  logic [31:0] exp_ctrl = '0, exp_sim = '0, exp_cfg = '0;
  logic [31:0] mem_model [256];

  // Pulse monitors and external memory, all on the falling edge.
  int          ctrl_pulse_cnt = 0, mem_wr_cnt = 0, mem_rd_cnt = 0, rd_en_cyc = 0;
  logic [7:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_pend_addr = '0;

  always @(negedge aclk) begin
    if (ctrl_wr_pulse) ctrl_pulse_cnt++;
    if (mem_wr_en) begin
      mem_wr_cnt++;
      last_wr_addr = mem_wr_addr;
      last_wr_data = mem_wr_data;
    end
    // Data is valid only in the cycle the responder samples it (2 edges after the request edge).
    if (rd_pend) mem_rd_data = mem_model[rd_pend_addr];
    else         mem_rd_data = $urandom;
    rd_pend      = mem_rd_en;
    rd_pend_addr = mem_rd_addr;
    if (mem_rd_en) begin
      mem_rd_cnt++;
      rd_en_cyc    = cyc;
      last_rd_addr = mem_rd_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_win(input logic [15:0] a);
    return a[15:8] == 8'h01;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    if (a == 16'h0000)      exp_ctrl = d;
    else if (a == 16'h0004) exp_sim = d;
    else if (a == 16'h0008) exp_cfg = d;
    else if (is_win(a))     mem_model[a[7:0]] = d;
    else                    resp = 2'b10;
  endtask

  task automatic model_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    d = '0;
    if (a == 16'h0000)      d = exp_ctrl;
    else if (a == 16'h0004) d = exp_sim;
    else if (a == 16'h0008) d = exp_cfg;
    else if (a == 16'h000C) d = debug_in;
    else if (is_win(a))     d = mem_model[a[7:0]];
    else                    resp = 2'b10;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return 16'h0000;
      1: return 16'h0004;
      2: return 16'h0008;
      3: return 16'h000C;
      4, 5: return {8'h01, 8'($urandom)};
      default: return {8'($urandom_range(2, 255)), 8'($urandom)};
    endcase
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    check("aw_w_handshake_timeout", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    check("bvalid_timeout", 32'(n < 20), 32'd1);
    resp = bresp;
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int rv_cyc);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    check("ar_handshake_timeout", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    check("rvalid_timeout", 32'(n < 20), 32'd1);
    rv_cyc = cyc;
    d = rdata;
    resp = rresp;
    @(posedge aclk); #1;
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] d, ed, rd, rd2;
    logic [1:0]  er, rs, rs2;
    logic [3:0]  s;
    int          pc, wc, rc, rvc, n;
    bit          held, seen;

    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

    // Reset: everything quiet and zero.
    repeat (3) @(negedge aclk);
    check("rst_handshake_outs",
          32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, ctrl_wr_pulse, mem_wr_en, mem_rd_en}),
          32'd0);
    check("rst_regs", ctrl_reg | sim_time_reg | mem_cfg_reg, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;

    do_read(16'h0000, rd, rs, rvc); check("rst_rd_ctrl", rd, 32'd0); check("rst_rresp_ctrl", 32'(rs), 32'd0);
    do_read(16'h0004, rd, rs, rvc); check("rst_rd_sim", rd, 32'd0);  check("rst_rresp_sim", 32'(rs), 32'd0);
    do_read(16'h0008, rd, rs, rvc); check("rst_rd_cfg", rd, 32'd0);  check("rst_rresp_cfg", 32'(rs), 32'd0);

    // CTRL write with all strobes low: full-word write regardless.
    pc = ctrl_pulse_cnt;
    model_write(16'h0000, 32'hDEADBEEF, er);
    do_write(16'h0000, 32'hDEADBEEF, 4'h0, rs);
    check("ctrl_bresp", 32'(rs), 32'd0);
    check("ctrl_reg", ctrl_reg, 32'hDEADBEEF);
    check("ctrl_pulse_cycles", 32'(ctrl_pulse_cnt - pc), 32'd1);
    do_read(16'h0000, rd, rs, rvc);
    check("ctrl_readback", rd, 32'hDEADBEEF);

    // Window write.
    wc = mem_wr_cnt;
    model_write(16'h0103, 32'h12345678, er);
    do_write(16'h0103, 32'h12345678, 4'hF, rs);
    check("win_wr_bresp", 32'(rs), 32'd0);
    check("win_wr_pulses", 32'(mem_wr_cnt - wc), 32'd1);
    check("win_wr_addr", 32'(last_wr_addr), 32'h03);
    check("win_wr_data", last_wr_data, 32'h12345678);

    // Window read with latency 2.
    mem_model[8'h02] = 32'hA5A5_0F0F;
    rc = mem_rd_cnt;
    do_read(16'h0102, rd, rs, rvc);
    check("win_rd_data", rd, 32'hA5A5_0F0F);
    check("win_rd_rresp", 32'(rs), 32'd0);
    check("win_rd_pulses", 32'(mem_rd_cnt - rc), 32'd1);
    check("win_rd_addr", 32'(last_rd_addr), 32'h02);
    check("win_rd_latency", 32'(rvc - rd_en_cyc), 32'(LAT));

    // Unmapped and read-only targets.
    do_write(16'h0040, 32'h1111_2222, 4'hF, rs);
    check("unmapped_wr_bresp", 32'(rs), 32'h2);
    do_write(16'h000C, 32'h3333_4444, 4'hF, rs);
    check("debug_wr_bresp", 32'(rs), 32'h2);
    check("unmapped_wr_ctrl", ctrl_reg, exp_ctrl);
    check("unmapped_wr_sim", sim_time_reg, exp_sim);
    check("unmapped_wr_cfg", mem_cfg_reg, exp_cfg);
    do_read(16'h0040, rd, rs, rvc);
    check("unmapped_rd_data", rd, 32'd0);
    check("unmapped_rd_rresp", 32'(rs), 32'h2);
    do_read(16'h000C, rd, rs, rvc);
    check("debug_rd_data", rd, 32'h0BAD_F00D);

    // B-channel backpressure: second write must wait for the B handshake.
    @(negedge aclk);
    bready = 1'b0;
    awaddr = 16'h0004; wdata = 32'hCAFE_0001; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    check("bp_first_accept", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    model_write(16'h0004, 32'hCAFE_0001, er);
    awaddr = 16'h0008; wdata = 32'hCAFE_0002;
    held = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (!bvalid || awready || wready) held = 1'b0;
    end
    check("bp_bvalid_held", 32'(held), 32'd1);
    check("bp_sim_written", sim_time_reg, 32'hCAFE_0001);
    check("bp_cfg_not_yet", mem_cfg_reg, exp_cfg);
    bready = 1'b1;
    @(posedge aclk); #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    check("bp_second_accept", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(16'h0008, 32'hCAFE_0002, er);
    n = 0;
    @(negedge aclk);
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    check("bp_second_bvalid", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    check("bp_cfg_written", mem_cfg_reg, 32'hCAFE_0002);

    // Same-cycle write and read to CTRL: read sees the old value.
    ed = exp_ctrl;
    model_write(16'h0000, 32'h5A5A_1234, er);
    fork
      do_write(16'h0000, 32'h5A5A_1234, 4'hF, rs2);
      do_read(16'h0000, rd2, rs, rvc);
    join
    check("same_cycle_old_value", rd2, ed);
    check("same_cycle_new_reg", ctrl_reg, 32'h5A5A_1234);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = pick_addr();
      d = $urandom;
      s = 4'($urandom);
      debug_in = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        pc = ctrl_pulse_cnt;
        wc = mem_wr_cnt;
        model_write(a, d, er);
        do_write(a, d, s, rs);
        check("rnd_bresp", 32'(rs), 32'(er));
        check("rnd_ctrl", ctrl_reg, exp_ctrl);
        check("rnd_sim", sim_time_reg, exp_sim);
        check("rnd_cfg", mem_cfg_reg, exp_cfg);
        check("rnd_ctrl_pulse", 32'(ctrl_pulse_cnt - pc), (a == 16'h0000) ? 32'd1 : 32'd0);
        check("rnd_memwr_pulse", 32'(mem_wr_cnt - wc), is_win(a) ? 32'd1 : 32'd0);
        if (is_win(a)) begin
          check("rnd_memwr_addr", 32'(last_wr_addr), 32'(a[7:0]));
          check("rnd_memwr_data", last_wr_data, d);
        end
      end else begin
        rc = mem_rd_cnt;
        model_read(a, ed, er);
        do_read(a, rd, rs, rvc);
        check("rnd_rdata", rd, ed);
        check("rnd_rresp", 32'(rs), 32'(er));
        check("rnd_memrd_pulse", 32'(mem_rd_cnt - rc), is_win(a) ? 32'd1 : 32'd0);
        if (is_win(a)) begin
          check("rnd_memrd_addr", 32'(last_rd_addr), 32'(a[7:0]));
          check("rnd_memrd_latency", 32'(rvc - rd_en_cyc), 32'(LAT));
        end
      end
    end

    // Reset while waiting on the memory: the read is dropped.
    @(negedge aclk);
    araddr = 16'h0155; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    check("rmem_ar_accept", 32'(n < 20), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check("rmem_rd_en", 32'(mem_rd_en), 32'd1);
    aresetn = 1'b0;
    exp_ctrl = '0; exp_sim = '0; exp_cfg = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (rvalid || mem_rd_en || bvalid) seen = 1'b1;
    end
    check("rmem_reset_no_rvalid", 32'(seen), 32'd0);
    check("rmem_reset_ctrl", ctrl_reg, exp_ctrl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
